seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, parametrised shift/rotate unit for the mini CPU datapath, succeeding the single-cycle arithmetic-right-shift ALU path. It accepts an operand, mode and amount on a start pulse and shifts STEP bits per clock. It then presents the result with carry and zero flags and a one-cycle done pulse. The datapath writes the result to Zlow, and the control sequencer waits on done instead of assuming a fixed cycle count.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥2)
- STEP, 1, bits shifted per cycle; power of two, 1..WIDTH
- AMT_W (localparam), $clog2(WIDTH), amount width

Ports:
- Clock  in  1  rising-edge clock
- clear  in  1  reset; asynchronous, active-high
- start  in  1  request; accepted only when busy=0
- mode  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
- operand  in  WIDTH  value to shift, sampled with start
- amount  in  AMT_W  shift count 0..WIDTH-1, sampled with start
- busy  out  1  high while shifting
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  shifted value; valid from done, held until next accepted start
- carry  out  1  last bit shifted/rotated out; 0 when amount=0
- zero  out  1  result==0; valid with done
- err  out  1  illegal mode; valid with done, held until next accepted start

## Operation
- FSM states:
  - IDLE: on start, latch mode, operand and amount; remaining=amount; go to SHIFT, or go to DONE if amount=0 or mode is illegal.
  - SHIFT: each cycle, shift by k=min(STEP, remaining) and subtract k from remaining. When remaining≤STEP, perform the final step and go to DONE.
  - DONE: done=1. A start in this state is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- SHR fills with zeros. SHRA replicates the latched MSB. SHL fills the LSB with zeros. ROR and ROL are circular.
- carry:
  - Right ops: operand bit (amount-1).
  - Left ops: operand bit (WIDTH-amount).
- Illegal mode: result=operand, carry=0, err=1.
- start while busy=1 is ignored; latched values are unaffected.
- Reset values: state IDLE, and busy, done, result, carry, zero, err all 0.
- clear mid-operation aborts immediately: done is not pulsed and all outputs return to their reset values.

## Timing
- start is sampled at the end of cycle 0, and n=ceil(amount/STEP).
- busy is high in cycles 1..n.
- done is high in cycle n+1 only (cycle 1 when amount=0 or mode is illegal).
- result, carry and zero are stable from cycle n+1 onwards.
- Worst-case latency is ceil((WIDTH-1)/STEP)+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- SEQ_SHIFTER_ROTATE_EN defined: ROR and ROL are implemented as above.
- Not defined:
  - Modes 011 and 100 are treated as illegal: result=operand, err=1, done in cycle 1.
  - Rotate logic is absent.

## Structure
- Package shifter_pkg holds:
  - mode encodings SHR, SHRA, SHL, ROR, ROL
  - the FSM state enum (IDLE, SHIFT, DONE)
- Sub-module shift_step is a combinational single-step shifter (value, mode, k → shifted value, bit out), instantiated once.

## Test plan
- SHRA, STEP=1, operand 0xFFFFFFF4 (-12), amount 5 -> result 0xFFFFFFFF, carry=1, zero=0, busy cycles 1..5, done in cycle 6.
- SHL, operand 0x80000001, amount 1 -> result 0x00000002, carry=1, done in cycle 2.
- ROR, STEP=4, operand 0x00000010, amount 5 (partial last step) -> result 0x80000000, carry=1, done in cycle 3.
- SHR, amount 0, operand 0x12345678 -> result 0x12345678, carry=0, done in cycle 1.
- mode 111, then ROR without SEQ_SHIFTER_ROTATE_EN -> result=operand, err=1, done in cycle 1.
- Start ignored while busy, then abort:
  - Stimulus: SHR amount 20, STEP=1; a second start in cycle 3; clear asserted in cycle 4.
  - Response: the second start is ignored; clear takes effect immediately; busy=0, result=0, done never pulses.
  - Recovery: a new start accepted afterwards completes normally.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
// SEQ_SHIFTER_ROTATE_EN enables the ROR/ROL modes; without it those encodings are illegal.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHR  = 3'b000,
    SHRA = 3'b001,
    SHL  = 3'b010,
    ROR  = 3'b011,
    ROL  = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic mode_legal(input logic [2:0] m);
`ifdef SEQ_SHIFTER_ROTATE_EN
    return (m == SHR) || (m == SHRA) || (m == SHL) || (m == ROR) || (m == ROL);
`else
    return (m == SHR) || (m == SHRA) || (m == SHL);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k bits and reports the last bit out.
// Rotate paths exist only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [2:0]       mode_i,
  input  logic [AMT_W-1:0] k_i,
  output logic [WIDTH-1:0] value_c,
  output logic             bit_c
);

  logic [AMT_W:0]   comp_k;
  logic [AMT_W-1:0] idx_r;
  logic [AMT_W-1:0] idx_l;

  always_comb begin
    comp_k  = (AMT_W+1)'(WIDTH) - {1'b0, k_i};
    idx_r   = k_i - AMT_W'(1);
    idx_l   = comp_k[AMT_W-1:0];
    value_c = value_i;
    bit_c   = 1'b0;
    // k=0 is a no-op step with no bit leaving the word
    if (k_i != '0) begin
      case (mode_i)
        SHR: begin
          value_c = value_i >> k_i;
          bit_c   = value_i[idx_r];
        end
        SHRA: begin
          value_c = WIDTH'($signed(value_i) >>> k_i);
          bit_c   = value_i[idx_r];
        end
        SHL: begin
          value_c = value_i << k_i;
          bit_c   = value_i[idx_l];
        end
`ifdef SEQ_SHIFTER_ROTATE_EN
        ROR: begin
          value_c = (value_i >> k_i) | (value_i << comp_k);
          bit_c   = value_i[idx_r];
        end
        ROL: begin
          value_c = (value_i << k_i) | (value_i >> comp_k);
          bit_c   = value_i[idx_l];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: STEP bits per clock, registered result/flags and a done pulse.
// Rotate modes are built only with SEQ_SHIFTER_ROTATE_EN defined.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             last_step_c;
  logic [AMT_W-1:0] k_c;
  logic [WIDTH-1:0] step_value_c;
  logic             step_bit_c;

  // Step size is min(STEP, remaining); only non-zero while shifting
  always_comb begin
    accept_c    = start && (state_q != SHIFT);
    last_step_c = 32'(remaining_q) <= STEP;
    k_c         = '0;
    if (state_q == SHIFT) begin
      k_c = last_step_c ? remaining_q : AMT_W'(STEP);
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (value_q),
    .mode_i  (mode_q),
    .k_i     (k_c),
    .value_c (step_value_c),
    .bit_c   (step_bit_c)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = ((amount == '0) || !mode_legal(mode)) ? DONE : SHIFT;
        else       state_d = IDLE;
      end
      SHIFT:   if (last_step_c) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag updates; result/flags load only on entry to DONE
  always_comb begin
    mode_d      = mode_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    busy_d      = (state_d == SHIFT);
    done_d      = (state_d == DONE);
    if (accept_c) begin
      mode_d      = mode;
      value_d     = operand;
      remaining_d = amount;
      err_d       = 1'b0;
      if (state_d == DONE) begin
        result_d = operand;
        carry_d  = 1'b0;
        zero_d   = (operand == '0);
        err_d    = !mode_legal(mode);
      end
    end else if (state_q == SHIFT) begin
      value_d     = step_value_c;
      remaining_d = remaining_q - k_c;
      if (last_step_c) begin
        result_d = step_value_c;
        carry_d  = step_bit_c;
        zero_d   = (step_value_c == '0);
      end
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      mode_q      <= '0;
      value_q     <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share stimulus and are checked
// each cycle against a bit-level reference model, plus hand-computed literal checks.
module tb_seq_shifter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam logic [2:0] M_SHR = 3'd0, M_SHRA = 3'd1, M_SHL = 3'd2, M_ROR = 3'd3, M_ROL = 3'd4;

  logic          Clock = 1'b0;
  logic          clear;
  logic          start;
  logic [2:0]    mode;
  logic [W-1:0]  operand;
  logic [AW-1:0] amount;

  logic          busy_o[2];
  logic          done_o[2];
  logic [W-1:0]  result_o[2];
  logic          carry_o[2];
  logic          zero_o[2];
  logic          err_o[2];

  seq_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
    .Clock(Clock), .clear(clear), .start(start), .mode(mode), .operand(operand),
    .amount(amount), .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]),
    .carry(carry_o[0]), .zero(zero_o[0]), .err(err_o[0]));

  seq_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
    .Clock(Clock), .clear(clear), .start(start), .mode(mode), .operand(operand),
    .amount(amount), .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]),
    .carry(carry_o[1]), .zero(zero_o[1]), .err(err_o[1]));

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bit-level definitions of each mode
  function automatic bit legal(input logic [2:0] m);
`ifdef SEQ_SHIFTER_ROTATE_EN
    return m <= M_ROL;
`else
    return m <= M_SHL;
`endif
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [2:0] m, input logic [W-1:0] op, input int amt);
    logic [W-1:0] r;
    r = op;
    if (legal(m) && amt != 0) begin
      for (int i = 0; i < W; i++) begin
        case (m)
          M_SHR:   r[i] = (i + amt < W) ? op[i + amt] : 1'b0;
          M_SHRA:  r[i] = (i + amt < W) ? op[i + amt] : op[W-1];
          M_SHL:   r[i] = (i - amt >= 0) ? op[i - amt] : 1'b0;
          M_ROR:   r[i] = op[(i + amt) % W];
          default: r[i] = op[(i - amt + W) % W];
        endcase
      end
    end
    return r;
  endfunction

  function automatic bit ref_carry(input logic [2:0] m, input logic [W-1:0] op, input int amt);
    if (!legal(m) || amt == 0) return 1'b0;
    if (m == M_SHR || m == M_SHRA || m == M_ROR) return op[amt - 1];
    return op[W - amt];
  endfunction

  int           step_of[2] = '{1, 4};
  bit           m_busy[2], m_done[2], m_carry[2], m_zero[2], m_err[2], m_valid[2];
  logic [W-1:0] m_result[2];
  int           m_left[2];
  bit           p_carry[2], p_err[2];
  logic [W-1:0] p_result[2];

  task automatic publish(input int s);
    m_busy[s]   = 1'b0;
    m_done[s]   = 1'b1;
    m_result[s] = p_result[s];
    m_carry[s]  = p_carry[s];
    m_zero[s]   = (p_result[s] == '0);
    m_err[s]    = p_err[s];
    m_valid[s]  = 1'b1;
  endtask

  always @(posedge Clock or posedge clear) begin
    for (int s = 0; s < 2; s++) begin
      if (clear) begin
        m_busy[s] = 0; m_done[s] = 0; m_result[s] = '0; m_carry[s] = 0;
        m_zero[s] = 0; m_err[s] = 0; m_valid[s] = 1; m_left[s] = 0;
      end else if (start && !m_busy[s]) begin
        int n;
        p_result[s] = ref_result(mode, operand, int'(amount));
        p_carry[s]  = ref_carry(mode, operand, int'(amount));
        p_err[s]    = !legal(mode);
        n = (p_err[s] || amount == 0) ? 0 : (int'(amount) + step_of[s] - 1) / step_of[s];
        if (n == 0) publish(s);
        else begin
          m_busy[s] = 1; m_left[s] = n; m_done[s] = 0; m_valid[s] = 0;
        end
      end else if (m_busy[s]) begin
        m_left[s]--;
        if (m_left[s] == 0) publish(s);
      end else begin
        m_done[s] = 0;
      end
    end
  end

  always @(negedge Clock) begin
    for (int s = 0; s < 2; s++) begin
      check($sformatf("busy[step%0d]", step_of[s]), W'(busy_o[s]), W'(m_busy[s]));
      check($sformatf("done[step%0d]", step_of[s]), W'(done_o[s]), W'(m_done[s]));
      if (m_valid[s]) begin
        check($sformatf("result[step%0d]", step_of[s]), result_o[s], m_result[s]);
        check($sformatf("carry[step%0d]", step_of[s]), W'(carry_o[s]), W'(m_carry[s]));
        check($sformatf("zero[step%0d]", step_of[s]), W'(zero_o[s]), W'(m_zero[s]));
        check($sformatf("err[step%0d]", step_of[s]), W'(err_o[s]), W'(m_err[s]));
      end
    end
  end

  int dcyc[2];

  // Waits for done on both instances; cycle 1 is the first cycle after the start edge
  task automatic wait_done();
    dcyc[0] = -1;
    dcyc[1] = -1;
    for (int c = 1; c <= 40; c++) begin
      for (int s = 0; s < 2; s++) if (done_o[s] && dcyc[s] < 0) dcyc[s] = c;
      if (dcyc[0] >= 0 && dcyc[1] >= 0) break;
      @(negedge Clock);
    end
  endtask

  task automatic run_op(input logic [2:0] m, input logic [W-1:0] op, input logic [AW-1:0] amt);
    @(negedge Clock);
    start = 1'b1; mode = m; operand = op; amount = amt;
    @(negedge Clock);
    start = 1'b0;
    wait_done();
  endtask

  task automatic check_op(input string name, input logic [W-1:0] res, input bit c, input bit z,
                          input bit e, input int d1, input int d4);
    check({name, ".result"}, result_o[0], res);
    check({name, ".carry"}, W'(carry_o[0]), W'(c));
    check({name, ".zero"}, W'(zero_o[0]), W'(z));
    check({name, ".err"}, W'(err_o[0]), W'(e));
    check({name, ".done_cycle_step1"}, W'(dcyc[0]), W'(d1));
    check({name, ".done_cycle_step4"}, W'(dcyc[1]), W'(d4));
  endtask

  initial begin
    int pulses;
    clear = 1'b1; start = 1'b0; mode = '0; operand = '0; amount = '0;
    repeat (2) @(negedge Clock);
    check("reset.busy", W'(busy_o[0]), '0);
    check("reset.result", result_o[1], '0);
    clear = 1'b0;

    run_op(M_SHRA, 32'hFFFF_FFF4, 5'd5);
    check_op("shra5", 32'hFFFF_FFFF, 1, 0, 0, 6, 3);
    run_op(M_SHL, 32'h8000_0001, 5'd1);
    check_op("shl1", 32'h0000_0002, 1, 0, 0, 2, 2);
    run_op(M_ROR, 32'h0000_0010, 5'd5);
`ifdef SEQ_SHIFTER_ROTATE_EN
    check_op("ror5", 32'h8000_0000, 1, 0, 0, 6, 3);
`else
    check_op("ror5", 32'h0000_0010, 0, 0, 1, 1, 1);
`endif
    run_op(M_SHR, 32'h1234_5678, 5'd0);
    check_op("shr0", 32'h1234_5678, 0, 0, 0, 1, 1);
    run_op(3'b111, 32'hA5A5_A5A5, 5'd9);
    check_op("illegal", 32'hA5A5_A5A5, 0, 0, 1, 1, 1);
    run_op(M_ROL, 32'h8000_0001, 5'd31);
`ifdef SEQ_SHIFTER_ROTATE_EN
    check_op("rol31", 32'hC000_0000, 0, 0, 0, 32, 9);
`else
    check_op("rol31", 32'h8000_0001, 0, 0, 1, 1, 1);
`endif
    run_op(M_SHR, 32'h8000_0000, 5'd31);
    check_op("shr31", 32'h0000_0001, 0, 0, 0, 32, 9);
    run_op(M_SHL, 32'h0000_0003, 5'd31);
    check_op("shl31", 32'h8000_0000, 1, 0, 0, 32, 9);
    run_op(M_SHR, 32'h0000_000F, 5'd4);
    check_op("shr_zero", 32'h0000_0000, 1, 1, 0, 5, 2);

    // Back-to-back: second start presented in the STEP=1 done cycle
    @(negedge Clock);
    start = 1'b1; mode = M_SHL; operand = 32'h0000_0001; amount = 5'd2;
    @(negedge Clock);
    start = 1'b0;
    for (int c = 0; c < 10 && !done_o[0]; c++) @(negedge Clock);
    check("b2b.first_result", result_o[0], 32'h0000_0004);
    start = 1'b1; mode = M_SHR; operand = 32'h0000_0100; amount = 5'd4;
    @(negedge Clock);
    start = 1'b0;
    wait_done();
    check("b2b.second_result", result_o[0], 32'h0000_0010);
    check("b2b.second_done_cycle", W'(dcyc[0]), W'(5));

    // Start while busy is ignored, then clear aborts mid-operation
    @(negedge Clock);
    start = 1'b1; mode = M_SHR; operand = 32'hF0F0_F0F0; amount = 5'd20;
    @(negedge Clock);
    start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    start = 1'b1; mode = M_SHL; operand = 32'hFFFF_FFFF; amount = 5'd0;
    @(negedge Clock);
    start = 1'b0;
    check("ignored.busy", W'(busy_o[0]), W'(1));
    check("ignored.done", W'(done_o[0]), '0);
    #2 clear = 1'b1;
    #1;
    check("abort.busy", W'(busy_o[0]), '0);
    check("abort.result", result_o[0], '0);
    check("abort.busy_step4", W'(busy_o[1]), '0);
    repeat (2) @(negedge Clock);
    clear = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clock);
      if (done_o[0] || done_o[1]) pulses++;
    end
    check("abort.no_done", W'(pulses), '0);

    run_op(M_SHR, 32'h1234_5678, 5'd4);
    check_op("recover", 32'h0123_4567, 1, 0, 0, 5, 2);

    repeat (2) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
